// File: rtl/req_ack_pkg.sv
// Shared types and defaults for the multi-channel request/acknowledge responder.
package req_ack_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, ACK} ra_state_e;

    localparam int unsigned N_CH_DEFAULT      = 4;
    localparam int unsigned MAX_DELAY_DEFAULT = 7;

    function automatic int unsigned clamp_delay(input int unsigned d, input int unsigned dmax);
        return (d > dmax) ? dmax : d;
    endfunction

endpackage

// File: rtl/req_ack_channel.sv
// One req/ack channel: IDLE/WAIT/ACK FSM, countdown counter and sticky overrun flag.
// Optional bounded-latency assertions/covers are compiled under REQ_ACK_RESPONDER_SVA_EN.
module req_ack_channel
    import req_ack_pkg::*;
#(
    parameter int unsigned MAX_DELAY = MAX_DELAY_DEFAULT,
    parameter int unsigned DW        = $clog2(MAX_DELAY + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          req_i,
    input  logic [DW-1:0] cfg_delay_i,
    input  logic          clr_overrun_i,
    output logic          ack_o,
    output logic          busy_o,
    output logic          overrun_o
);

    ra_state_e     state_q, state_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic          overrun_q, overrun_d;
    logic [DW-1:0] de;
    logic          accept;

    assign de     = DW'(clamp_delay(32'(cfg_delay_i), MAX_DELAY));
    assign accept = req_i && (state_q != WAIT);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE, ACK: begin
                if (accept) begin
                    if (de == '0) begin
                        state_d = ACK;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = de - DW'(1);
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - DW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // A dropped request outranks a same-cycle clear.
    always_comb begin
        overrun_d = overrun_q;
        if (req_i && (state_q == WAIT)) begin
            overrun_d = 1'b1;
        end else if (clr_overrun_i) begin
            overrun_d = 1'b0;
        end
    end

    always_comb begin
        ack_o     = (state_q == ACK);
        busy_o    = (state_q == WAIT);
        overrun_o = overrun_q;
    end

`ifdef REQ_ACK_RESPONDER_SVA_EN
    default clocking cb @(posedge clk_i);
    endclocking

    default disable iff (!rst_ni);

    property p_ack_exact;
        int unsigned d;
        (accept, d = int'(de) + 1) ##0 (d > 0, d = d - 1)[*1:$] ##1 (d == 0) |-> ack_o;
    endproperty

    a_ack_bounded: assert property (accept |-> ##[1:MAX_DELAY+1] ack_o);
    a_ack_exact:   assert property (p_ack_exact);
    a_ack_pulse:   assert property (ack_o |=> !ack_o || $past(req_i));
    a_no_spurious: assert property (ack_o |-> $past(state_q == WAIT && cnt_q == '0)
                                           || $past(accept && de == '0));

    c_ack_d0:       cover property (accept && de == '0 ##1 ack_o);
    c_ack_dmax:     cover property (accept && de == DW'(MAX_DELAY) ##(MAX_DELAY+1) ack_o);
    c_back_to_back: cover property (ack_o && req_i);
    c_overrun:      cover property (req_i && state_q == WAIT);
`endif

endmodule

// File: rtl/req_ack_responder.sv
// N_CH independent request/acknowledge channels with programmable, clamped ack latency.
// Define REQ_ACK_RESPONDER_SVA_EN to compile the per-channel latency assertions and covers.
module req_ack_responder
    import req_ack_pkg::*;
#(
    parameter int unsigned N_CH      = N_CH_DEFAULT,
    parameter int unsigned MAX_DELAY = MAX_DELAY_DEFAULT,
    localparam int unsigned DW       = $clog2(MAX_DELAY + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_CH-1:0]          req,
    input  logic [N_CH-1:0][DW-1:0]  cfg_delay,
    input  logic                     clr_overrun,
    output logic [N_CH-1:0]          ack,
    output logic [N_CH-1:0]          busy,
    output logic [N_CH-1:0]          overrun
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        req_ack_channel #(
            .MAX_DELAY (MAX_DELAY),
            .DW        (DW)
        ) u_channel (
            .clk_i         (clk),
            .rst_ni        (rst_n),
            .req_i         (req[i]),
            .cfg_delay_i   (cfg_delay[i]),
            .clr_overrun_i (clr_overrun),
            .ack_o         (ack[i]),
            .busy_o        (busy[i]),
            .overrun_o     (overrun[i])
        );
    end

endmodule
